// File: rtl/max_pool_ctrl.sv
// Sequencer for the max_pool datapath: accepts one pixel per cycle, tracks column/row
// position and drives the pair-max, row-FIFO and vertical-compare strobes.
module max_pool_ctrl #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 16
) (
    input  logic       sclk,
    input  logic       s_rst,
    input  logic       cfg_stride,
    input  logic       start,
    input  logic       in_vld,
    output logic       in_rdy,
    output logic       data_in_vld,
    output logic       pool_stride,
    output logic [3:0] row_cnt,
    output logic       fifo_wr_en,
    output logic       fifo_rd_en,
    output logic       out_vld,
    output logic       busy,
    output logic       done,
    output logic       pair_err
);

    localparam int COL_W = $clog2(IMG_W);
    localparam logic [COL_W-1:0] COL_LAST    = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0] COL_ONE     = COL_W'(1);
    localparam logic [3:0]       ROW_LAST    = 4'(IMG_H - 1);
    localparam logic [3:0]       ROW_WR_LAST = 4'(IMG_H - 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [3:0]       row_q, row_d;
    logic [3:0]       row_cnt_q, row_cnt_d;
    logic             flush_q, flush_d;
    logic             stride_q, stride_d;
    logic             pair_err_q, pair_err_d;
    logic             rdy_q, rdy_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             wr_q, wr_d;
    logic             out_p1_q, out_p1_d;
    logic             out_q;

    logic accept_s;
    logic odd_s;
    logic last_s;
    logic wr_row_s;
    logic rd_row_s;
    logic out_row_s;

    assign accept_s  = in_vld & rdy_q;
    assign odd_s     = col_q[0];
    assign last_s    = accept_s && (col_q == COL_LAST) && (row_q == ROW_LAST);
    assign wr_row_s  = stride_q ? (row_q <= ROW_WR_LAST) : ~row_q[0];
    assign rd_row_s  = stride_q ? (row_q != 4'd0) : row_q[0];
    assign out_row_s = stride_q ? 1'b1 : row_q[0];

    // Next-state, position tracking and strobe decode
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        flush_d    = flush_q;
        stride_d   = stride_q;
        pair_err_d = pair_err_q;
        row_cnt_d  = accept_s ? row_q : row_cnt_q;
        wr_d       = accept_s & odd_s & wr_row_s;
        out_p1_d   = accept_s & odd_s & out_row_s;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RUN;
                    col_d      = '0;
                    row_d      = 4'd0;
                    stride_d   = cfg_stride;
                    pair_err_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_s) begin
                    state_d = S_FLUSH;
                    flush_d = 1'b0;
                    col_d   = '0;
                    row_d   = 4'd0;
                end else if (accept_s) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + 4'd1;
                    end else begin
                        col_d = col_q + COL_ONE;
                    end
                end else if (odd_s) begin
                    // lost second half of a pair: rewind so upstream can resend it
                    pair_err_d = 1'b1;
                    col_d      = col_q - COL_ONE;
                end else begin
                    col_d = col_q;
                end
            end
            S_FLUSH: begin
                if (flush_q) begin
                    state_d = S_DONE;
                    flush_d = 1'b0;
                end else begin
                    flush_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        rdy_d  = (state_d == S_RUN);
        busy_d = (state_d == S_RUN) || (state_d == S_FLUSH);
        done_d = (state_d == S_DONE);
    end

    // State, counters and delayed strobe pipeline
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state_q    <= S_IDLE;
            col_q      <= '0;
            row_q      <= 4'd0;
            row_cnt_q  <= 4'd0;
            flush_q    <= 1'b0;
            stride_q   <= 1'b0;
            pair_err_q <= 1'b0;
            rdy_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_q       <= 1'b0;
            out_p1_q   <= 1'b0;
            out_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_cnt_q  <= row_cnt_d;
            flush_q    <= flush_d;
            stride_q   <= stride_d;
            pair_err_q <= pair_err_d;
            rdy_q      <= rdy_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wr_q       <= wr_d;
            out_p1_q   <= out_p1_d;
            out_q      <= out_p1_q;
        end
    end

    assign in_rdy      = rdy_q;
    assign data_in_vld = accept_s;
    assign fifo_rd_en  = accept_s & odd_s & rd_row_s;
    assign fifo_wr_en  = wr_q;
    assign out_vld     = out_q;
    assign pool_stride = stride_q;
    assign row_cnt     = row_cnt_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pair_err    = pair_err_q;

endmodule

// File: tb/tb_max_pool_ctrl.sv
// Scoreboard bench for max_pool_ctrl on a 4x4 frame: the driver model predicts every
// strobe cycle from the pixel position, a negedge monitor pops and compares.
module tb_max_pool_ctrl;

    localparam int W = 4;
    localparam int H = 4;

    logic       sclk = 1'b0;
    logic       s_rst = 1'b1;
    logic       cfg_stride = 1'b0;
    logic       start = 1'b0;
    logic       in_vld = 1'b0;
    logic       in_rdy, data_in_vld, pool_stride, fifo_wr_en, fifo_rd_en;
    logic       out_vld, busy, done, pair_err;
    logic [3:0] row_cnt;

    max_pool_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
        .sclk(sclk), .s_rst(s_rst), .cfg_stride(cfg_stride), .start(start),
        .in_vld(in_vld), .in_rdy(in_rdy), .data_in_vld(data_in_vld),
        .pool_stride(pool_stride), .row_cnt(row_cnt), .fifo_wr_en(fifo_wr_en),
        .fifo_rd_en(fifo_rd_en), .out_vld(out_vld), .busy(busy), .done(done),
        .pair_err(pair_err)
    );

    always #5 sclk = ~sclk;

    int cyc = 0;
    always @(posedge sclk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // expected event cycles; write entries also carry the row (cycle*16 + row)
    int wr_q[$];
    int rd_q[$];
    int out_q[$];
    int done_q[$];

    int mcol = 0, mrow = 0;
    bit m_run = 0, m_rdy = 0, m_stride = 0, m_perr = 0, mon_on = 0;
    int n_wr = 0, n_rd = 0, n_out = 0;
    int mon_e;

    always @(negedge sclk) begin
        if (mon_on) begin
            check_val("in_rdy", int'(in_rdy), int'(m_rdy));
            check_val("data_in_vld", int'(data_in_vld), int'(in_vld & m_rdy));
            if (fifo_wr_en) begin
                n_wr++;
                if (wr_q.size() == 0) check_val("wr_spurious", 1, 0);
                else begin
                    mon_e = wr_q.pop_front();
                    check_val("wr_cycle", cyc, mon_e / 16);
                    check_val("wr_row_cnt", int'(row_cnt), mon_e % 16);
                end
            end
            if (wr_q.size() > 0 && wr_q[0] / 16 < cyc) begin
                check_val("wr_missing", cyc, wr_q[0] / 16);
                void'(wr_q.pop_front());
            end
            if (fifo_rd_en) begin
                n_rd++;
                if (rd_q.size() == 0) check_val("rd_spurious", 1, 0);
                else begin
                    mon_e = rd_q.pop_front();
                    check_val("rd_cycle", cyc, mon_e);
                end
            end
            if (rd_q.size() > 0 && rd_q[0] < cyc) begin
                check_val("rd_missing", cyc, rd_q[0]);
                void'(rd_q.pop_front());
            end
            if (out_vld) begin
                n_out++;
                check_val("pool_stride", int'(pool_stride), int'(m_stride));
                if (out_q.size() == 0) check_val("out_spurious", 1, 0);
                else begin
                    mon_e = out_q.pop_front();
                    check_val("out_cycle", cyc, mon_e);
                end
            end
            if (out_q.size() > 0 && out_q[0] < cyc) begin
                check_val("out_missing", cyc, out_q[0]);
                void'(out_q.pop_front());
            end
            if (done) begin
                check_val("busy_at_done", int'(busy), 0);
                if (done_q.size() == 0) check_val("done_spurious", 1, 0);
                else begin
                    mon_e = done_q.pop_front();
                    check_val("done_cycle", cyc, mon_e);
                end
            end
            if (done_q.size() > 0 && done_q[0] < cyc) begin
                check_val("done_missing", cyc, done_q[0]);
                void'(done_q.pop_front());
            end
        end
    end

    // one cycle of stimulus plus the reference model update for that cycle
    task automatic pix(input logic vld, input logic st, input logic rst);
        int t;
        @(posedge sclk);
        #1;
        in_vld = vld;
        start  = st;
        s_rst  = rst;
        t      = cyc;
        m_rdy  = m_run;
        if (rst) begin
            m_run = 0;
        end else if (m_run && vld) begin
            if (mcol[0]) begin
                if (m_stride ? (mrow <= H - 2) : !mrow[0]) wr_q.push_back((t + 1) * 16 + mrow);
                if (m_stride ? (mrow >= 1) : mrow[0]) rd_q.push_back(t);
                if (m_stride || mrow[0]) out_q.push_back(t + 2);
            end
            if (mcol == W - 1) begin
                mcol = 0;
                if (mrow == H - 1) begin
                    m_run = 0;
                    done_q.push_back(t + 3);
                end else begin
                    mrow++;
                end
            end else begin
                mcol++;
            end
        end else if (m_run && mcol[0]) begin
            mcol--;
            m_perr = 1;
        end
    endtask

    // mode: 0 continuous, 1 gaps before pairs, 2 pair violation, 3 abort by reset, 4 stray starts
    task automatic run_frame(input bit s, input int mode, input string name);
        int guard = 0;
        int gcnt = 0;
        bit vdone = 0;
        bit sdone = 0;
        cfg_stride = s;
        pix(1'b0, 1'b1, 1'b0);
        m_run = 1; mcol = 0; mrow = 0; m_stride = s; m_perr = 0;
        n_wr = 0; n_rd = 0; n_out = 0;
        while (m_run && guard < 200) begin
            guard++;
            if (mode == 1 && !mcol[0] && (mcol != 0 || mrow != 0) && gcnt < 3) begin
                pix(1'b0, 1'b0, 1'b0);
                gcnt++;
            end else if (mode == 2 && !vdone && mrow == 1 && mcol == 3) begin
                pix(1'b0, 1'b0, 1'b0);
                vdone = 1;
            end else if (mode == 3 && mrow == 2 && mcol == 2) begin
                break;
            end else if (mode == 4 && !sdone && mrow == 1 && mcol == 0) begin
                cfg_stride = ~s;
                pix(1'b1, 1'b1, 1'b0);
                cfg_stride = s;
                sdone = 1;
            end else begin
                pix(1'b1, 1'b0, 1'b0);
                if (mcol[0]) gcnt = 0;
            end
        end
        check_val({name, "_bounded"}, int'(guard < 200), 1);
        if (mode == 3) begin
            repeat (3) pix(1'b0, 1'b0, 1'b0);
            pix(1'b0, 1'b0, 1'b1);
            pix(1'b0, 1'b0, 1'b1);
            pix(1'b0, 1'b0, 1'b0);
            @(negedge sclk);
            check_val({name, "_busy_after_rst"}, int'(busy), 0);
            check_val({name, "_row_cnt_after_rst"}, int'(row_cnt), 0);
            repeat (6) pix(1'b0, 1'b0, 1'b0);
        end else begin
            pix(1'b0, 1'b0, 1'b0);
            @(negedge sclk);
            check_val({name, "_busy_flush"}, int'(busy), 1);
            pix(1'b0, 1'b0, 1'b0);
            pix(1'b0, (mode == 4) ? 1'b1 : 1'b0, 1'b0);
            repeat (3) begin
                pix(1'b0, 1'b0, 1'b0);
                @(negedge sclk);
                check_val({name, "_busy_idle"}, int'(busy), 0);
            end
            check_val({name, "_pair_err"}, int'(pair_err), int'(m_perr));
            check_val({name, "_out_cnt"}, n_out, s ? (W / 2) * H : (W / 2) * (H / 2));
            check_val({name, "_wr_cnt"}, n_wr, s ? (W / 2) * (H - 1) : (W / 2) * (H / 2));
            check_val({name, "_rd_cnt"}, n_rd, s ? (W / 2) * (H - 1) : (W / 2) * (H / 2));
        end
    endtask

    initial begin
        repeat (3) @(posedge sclk);
        @(negedge sclk);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_in_rdy", int'(in_rdy), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_out_vld", int'(out_vld), 0);
        check_val("rst_wr_en", int'(fifo_wr_en), 0);
        check_val("rst_pair_err", int'(pair_err), 0);
        check_val("rst_row_cnt", int'(row_cnt), 0);
        check_val("rst_pool_stride", int'(pool_stride), 0);
        mon_on = 1;
        pix(1'b0, 1'b0, 1'b0);

        run_frame(1'b0, 0, "t1");
        run_frame(1'b1, 0, "t2");
        run_frame(1'b0, 1, "t3");
        run_frame(1'b0, 2, "t4");
        run_frame(1'b0, 3, "t5_abort");
        run_frame(1'b0, 0, "t5_rerun");
        run_frame(1'b0, 4, "t6");

        check_val("wr_q_empty", wr_q.size(), 0);
        check_val("rd_q_empty", rd_q.size(), 0);
        check_val("out_q_empty", out_q.size(), 0);
        check_val("done_q_empty", done_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
